// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the MEM stage: access-size codes, lane
// geometry, alignment check and byte-lane mask generation.
package mem_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b11;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int LANES  = 4;

  // The reserved size code 2'b10 behaves exactly like a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      MEM_BYTE: is_misaligned = 1'b0;
      MEM_HALF: is_misaligned = lane[0];
      default:  is_misaligned = (lane != 2'b00);
    endcase
  endfunction

  function automatic logic [LANES-1:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      MEM_BYTE: lane_mask = 4'b0001 << lane;
      MEM_HALF: lane_mask = lane[1] ? 4'b1100 : 4'b0011;
      default:  lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/data_memory.sv
// Byte-enable data RAM: synchronous write and clear, asynchronous pipeline
// and debug read ports.
module data_memory
  import mem_pkg::*;
#(
  parameter int BUS_WIDTH      = 32,
  parameter int MEM_ADDR_WIDTH = 5
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [BUS_WIDTH/8-1:0]    i_byte_en,
  input  logic [MEM_ADDR_WIDTH-1:0] i_addr,
  input  logic [BUS_WIDTH-1:0]      i_wdata,
  output logic [BUS_WIDTH-1:0]      o_rdata,
  input  logic [MEM_ADDR_WIDTH-1:0] i_debug_addr,
  output logic [BUS_WIDTH-1:0]      o_debug_data
);

  localparam int DEPTH    = 1 << MEM_ADDR_WIDTH;
  localparam int NUM_LANE = BUS_WIDTH / BYTE_W;

  logic [BUS_WIDTH-1:0] mem_q [DEPTH];
  logic [BUS_WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    for (int l = 0; l < NUM_LANE; l++) begin
      if (i_byte_en[l]) begin
        mem_d[i_addr][l*BYTE_W +: BYTE_W] = i_wdata[l*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Reads see the pre-edge contents, which gives read-before-write ordering.
  assign o_rdata      = mem_q[i_addr];
  assign o_debug_data = mem_q[i_debug_addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS32 MEM stage: store lane steering, misalignment detection, load
// extraction/extension, data memory and the MEM/WB pipeline register.
module mem_stage
  import mem_pkg::*;
#(
  parameter int BUS_WIDTH      = 32,
  parameter int MEM_ADDR_WIDTH = 5,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic [BUS_WIDTH-1:0]      i_alu_result,
  input  logic [BUS_WIDTH-1:0]      i_store_data,
  input  logic                      i_mem_read,
  input  logic                      i_mem_write,
  input  logic [1:0]                i_mem_size,
  input  logic                      i_mem_unsigned,
  input  logic                      i_mem_to_reg,
  input  logic                      i_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] i_rd,
  input  logic [MEM_ADDR_WIDTH-1:0] i_debug_addr,
  output logic [BUS_WIDTH-1:0]      o_debug_data,
  output logic [BUS_WIDTH-1:0]      o_alu_result,
  output logic [BUS_WIDTH-1:0]      o_mem_result,
  output logic                      o_mem_to_reg,
  output logic                      o_reg_write,
  output logic [REG_ADDR_WIDTH-1:0] o_rd,
  output logic                      o_misaligned
);

  logic [MEM_ADDR_WIDTH-1:0] word_idx;
  logic [1:0]                lane;
  logic                      misaligned;
  logic [LANES-1:0]          byte_en;
  logic [BUS_WIDTH-1:0]      wdata;
  logic [BUS_WIDTH-1:0]      rdata;
  logic [BYTE_W-1:0]         ld_byte;
  logic [HALF_W-1:0]         ld_half;
  logic [BUS_WIDTH-1:0]      load_data;

  logic [BUS_WIDTH-1:0]      alu_result_q, alu_result_d;
  logic [BUS_WIDTH-1:0]      mem_result_q, mem_result_d;
  logic                      mem_to_reg_q, mem_to_reg_d;
  logic                      reg_write_q,  reg_write_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q,         rd_d;
  logic                      misaligned_q, misaligned_d;

  assign word_idx   = i_alu_result[MEM_ADDR_WIDTH+1:2];
  assign lane       = i_alu_result[1:0];
  assign misaligned = (i_mem_read | i_mem_write) & is_misaligned(i_mem_size, lane);
  assign byte_en    = (i_enable && i_mem_write && !misaligned) ? lane_mask(i_mem_size, lane) : '0;

  // Replicating the source onto every lane lets the byte enables pick the target.
  always_comb begin
    case (i_mem_size)
      MEM_BYTE: wdata = {LANES{i_store_data[BYTE_W-1:0]}};
      MEM_HALF: wdata = {(LANES/2){i_store_data[HALF_W-1:0]}};
      default:  wdata = i_store_data;
    endcase
  end

  data_memory #(
    .BUS_WIDTH     (BUS_WIDTH),
    .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH)
  ) u_data_memory (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_byte_en   (byte_en),
    .i_addr      (word_idx),
    .i_wdata     (wdata),
    .o_rdata     (rdata),
    .i_debug_addr(i_debug_addr),
    .o_debug_data(o_debug_data)
  );

  assign ld_byte = rdata[lane*BYTE_W +: BYTE_W];
  assign ld_half = lane[1] ? rdata[2*HALF_W-1:HALF_W] : rdata[HALF_W-1:0];

  always_comb begin
    load_data = '0;
    if (i_mem_read && !misaligned) begin
      case (i_mem_size)
        MEM_BYTE: load_data = {{(BUS_WIDTH-BYTE_W){ld_byte[BYTE_W-1] & ~i_mem_unsigned}}, ld_byte};
        MEM_HALF: load_data = {{(BUS_WIDTH-HALF_W){ld_half[HALF_W-1] & ~i_mem_unsigned}}, ld_half};
        default:  load_data = rdata;
      endcase
    end
  end

  always_comb begin
    alu_result_d = alu_result_q;
    mem_result_d = mem_result_q;
    mem_to_reg_d = mem_to_reg_q;
    reg_write_d  = reg_write_q;
    rd_d         = rd_q;
    misaligned_d = misaligned_q;
    if (i_enable) begin
      alu_result_d = i_alu_result;
      mem_result_d = load_data;
      mem_to_reg_d = i_mem_to_reg;
      reg_write_d  = i_reg_write;
      rd_d         = i_rd;
      misaligned_d = misaligned;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      alu_result_q <= '0;
      mem_result_q <= '0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      misaligned_q <= 1'b0;
    end else begin
      alu_result_q <= alu_result_d;
      mem_result_q <= mem_result_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      rd_q         <= rd_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign o_alu_result = alu_result_q;
  assign o_mem_result = mem_result_q;
  assign o_mem_to_reg = mem_to_reg_q;
  assign o_reg_write  = reg_write_q;
  assign o_rd         = rd_q;
  assign o_misaligned = misaligned_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stores, lane steering, misalignment,
// stall, address wrap and reset clearing, against hand-computed values.
module tb_mem_stage;
  import mem_pkg::*;

  logic        i_clk;
  logic        i_reset;
  logic        i_enable;
  logic [31:0] i_alu_result;
  logic [31:0] i_store_data;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [1:0]  i_mem_size;
  logic        i_mem_unsigned;
  logic        i_mem_to_reg;
  logic        i_reg_write;
  logic [4:0]  i_rd;
  logic [4:0]  i_debug_addr;
  logic [31:0] o_debug_data;
  logic [31:0] o_alu_result;
  logic [31:0] o_mem_result;
  logic        o_mem_to_reg;
  logic        o_reg_write;
  logic [4:0]  o_rd;
  logic        o_misaligned;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_enable      (i_enable),
    .i_alu_result  (i_alu_result),
    .i_store_data  (i_store_data),
    .i_mem_read    (i_mem_read),
    .i_mem_write   (i_mem_write),
    .i_mem_size    (i_mem_size),
    .i_mem_unsigned(i_mem_unsigned),
    .i_mem_to_reg  (i_mem_to_reg),
    .i_reg_write   (i_reg_write),
    .i_rd          (i_rd),
    .i_debug_addr  (i_debug_addr),
    .o_debug_data  (o_debug_data),
    .o_alu_result  (o_alu_result),
    .o_mem_result  (o_mem_result),
    .o_mem_to_reg  (o_mem_to_reg),
    .o_reg_write   (o_reg_write),
    .o_rd          (o_rd),
    .o_misaligned  (o_misaligned)
  );

  // Clock
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_dbg(input string tag, input logic [4:0] idx, input logic [31:0] expected);
    i_debug_addr = idx;
    #1;
    check(tag, o_debug_data, expected);
  endtask

  // Drives one instruction into MEM and returns #1 after the capturing edge.
  task automatic op(input logic [31:0] addr, input logic [31:0] data,
                    input logic rd_en, input logic wr_en, input logic [1:0] size,
                    input logic uns, input logic m2r, input logic rw, input logic [4:0] rd);
    i_enable       = 1'b1;
    i_alu_result   = addr;
    i_store_data   = data;
    i_mem_read     = rd_en;
    i_mem_write    = wr_en;
    i_mem_size     = size;
    i_mem_unsigned = uns;
    i_mem_to_reg   = m2r;
    i_reg_write    = rw;
    i_rd           = rd;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    op(32'h0, 32'h0, 1'b0, 1'b0, MEM_WORD, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    i_reset = 1'b1;
    i_debug_addr = '0;
    idle();
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;

    // 1. random traffic, then reset for two cycles
    for (int n = 0; n < 6; n++) begin
      op($urandom_range(0, 31) << 2, $urandom, 1'($urandom_range(0, 1)), 1'b1, MEM_WORD,
         1'b0, 1'b1, 1'b1, 5'($urandom_range(1, 31)));
    end
    i_reset = 1'b1;
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    check("rst_alu", o_alu_result, 32'h0);
    check("rst_mem", o_mem_result, 32'h0);
    check("rst_m2r", 32'(o_mem_to_reg), 32'h0);
    check("rst_rw",  32'(o_reg_write), 32'h0);
    check("rst_rd",  32'(o_rd), 32'h0);
    check("rst_mis", 32'(o_misaligned), 32'h0);
    for (int w = 0; w < 32; w++) begin
      check($sformatf("rst_dump%0d", w), 32'h0, 32'h0 | o_debug_data_at(5'(w)));
    end
    i_reset = 1'b0;

    // 2. word store then loads of each width
    op(32'h8, 32'hDEADBEEF, 1'b0, 1'b1, MEM_WORD, 1'b0, 1'b0, 1'b0, 5'd0);
    check("sw_mem_result", o_mem_result, 32'h0);
    check_dbg("sw_word2", 5'd2, 32'hDEADBEEF);
    op(32'h8, 32'h0, 1'b1, 1'b0, MEM_WORD, 1'b0, 1'b1, 1'b1, 5'd3);
    check("lw", o_mem_result, 32'hDEADBEEF);
    check("lw_rd", 32'(o_rd), 32'd3);
    op(32'h9, 32'h0, 1'b1, 1'b0, MEM_BYTE, 1'b0, 1'b1, 1'b1, 5'd4);
    check("lb", o_mem_result, 32'hFFFFFFBE);
    op(32'h9, 32'h0, 1'b1, 1'b0, MEM_BYTE, 1'b1, 1'b1, 1'b1, 5'd4);
    check("lbu", o_mem_result, 32'h000000BE);
    op(32'hA, 32'h0, 1'b1, 1'b0, MEM_HALF, 1'b0, 1'b1, 1'b1, 5'd4);
    check("lh", o_mem_result, 32'hFFFFDEAD);
    op(32'hA, 32'h0, 1'b1, 1'b0, MEM_HALF, 1'b1, 1'b1, 1'b1, 5'd4);
    check("lhu", o_mem_result, 32'h0000DEAD);
    op(32'h8, 32'h0, 1'b1, 1'b0, MEM_BYTE, 1'b0, 1'b1, 1'b1, 5'd4);
    check("lb_lane0", o_mem_result, 32'hFFFFFFEF);

    // 3. partial stores touch only their lanes
    op(32'hB, 32'hFFFFFF11, 1'b0, 1'b1, MEM_BYTE, 1'b0, 1'b0, 1'b0, 5'd0);
    check_dbg("sb_word2", 5'd2, 32'h11ADBEEF);
    op(32'h8, 32'hFFFF2222, 1'b0, 1'b1, MEM_HALF, 1'b0, 1'b0, 1'b0, 5'd0);
    check_dbg("sh_word2", 5'd2, 32'h11AD2222);

    // 4. misaligned accesses
    op(32'h6, 32'h12345678, 1'b0, 1'b1, MEM_WORD, 1'b0, 1'b0, 1'b0, 5'd0);
    check("sw_mis_flag", 32'(o_misaligned), 32'h1);
    check_dbg("sw_mis_word1", 5'd1, 32'h0);
    op(32'h3, 32'h0, 1'b1, 1'b0, MEM_HALF, 1'b0, 1'b1, 1'b1, 5'd6);
    check("lh_mis_result", o_mem_result, 32'h0);
    check("lh_mis_flag", 32'(o_misaligned), 32'h1);
    op(32'h3, 32'h0, 1'b1, 1'b0, MEM_BYTE, 1'b1, 1'b1, 1'b1, 5'd6);
    check("lbu_odd_flag", 32'(o_misaligned), 32'h0);
    check("lbu_odd", o_mem_result, 32'h0);

    // simultaneous read and write: write lands, load sees old value
    op(32'h8, 32'hCAFEF00D, 1'b1, 1'b1, MEM_WORD, 1'b0, 1'b1, 1'b1, 5'd7);
    check("rw_old", o_mem_result, 32'h11AD2222);
    check_dbg("rw_new", 5'd2, 32'hCAFEF00D);

    // 5. stall with a store pending
    op(32'h8, 32'h0, 1'b1, 1'b0, MEM_WORD, 1'b0, 1'b1, 1'b1, 5'd5);
    check("pre_stall", o_mem_result, 32'hCAFEF00D);
    i_enable       = 1'b0;
    i_alu_result   = 32'hC;
    i_store_data   = 32'h55667788;
    i_mem_read     = 1'b0;
    i_mem_write    = 1'b1;
    i_mem_size     = MEM_WORD;
    i_mem_to_reg   = 1'b0;
    i_reg_write    = 1'b0;
    i_rd           = 5'd9;
    for (int c = 0; c < 3; c++) begin
      @(posedge i_clk);
      #1;
      check("stall_alu", o_alu_result, 32'h8);
      check("stall_mem", o_mem_result, 32'hCAFEF00D);
      check("stall_rd",  32'(o_rd), 32'd5);
      check("stall_rw",  32'(o_reg_write), 32'h1);
      check_dbg("stall_word3", 5'd3, 32'h0);
    end
    check_dbg("stall_dbg_track", 5'd2, 32'hCAFEF00D);
    op(32'hC, 32'h55667788, 1'b0, 1'b1, MEM_WORD, 1'b0, 1'b0, 1'b0, 5'd9);
    check_dbg("unstall_word3", 5'd3, 32'h55667788);
    check("unstall_alu", o_alu_result, 32'hC);
    check("unstall_mem", o_mem_result, 32'h0);
    check("unstall_rd",  32'(o_rd), 32'd9);

    // 6. address wrap and pass-through
    op(32'h80, 32'hA5A5A5A5, 1'b0, 1'b1, MEM_WORD, 1'b0, 1'b1, 1'b1, 5'd17);
    check_dbg("wrap_word0", 5'd0, 32'hA5A5A5A5);
    check("wrap_alu", o_alu_result, 32'h80);
    check("wrap_rd",  32'(o_rd), 32'd17);
    check("wrap_rw",  32'(o_reg_write), 32'h1);
    check("wrap_m2r", 32'(o_mem_to_reg), 32'h1);
    op(32'h7F, 32'h0, 1'b1, 1'b0, MEM_BYTE, 1'b1, 1'b0, 1'b0, 5'd0);
    check("wrap_lbu_word31", o_mem_result, 32'h0);
    check("pass_rw_clear", 32'(o_reg_write), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic [31:0] o_debug_data_at(input logic [4:0] idx);
    return dut.u_data_memory.mem_q[idx];
  endfunction

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage of the 5-stage MIPS32 pipeline, sitting between EX and WB.
- Contains the byte-addressable data memory, store lane steering, load extraction with sign/zero extension, and the MEM/WB pipeline register.
- Its registered outputs feed the write-back mux directly: ALU result, memory result, mem-to-reg select, register-write control and destination.
- A combinational debug read port lets the debug unit dump data memory.

Parameters:
BUS_WIDTH, 32, data/address bus width.
MEM_ADDR_WIDTH, 5, log2 of data-memory depth in 32-bit words (default 32 words).
REG_ADDR_WIDTH, 5, register-file index width.

Ports:
i_clk  in  1  clock; all state updates on the rising edge.
i_reset  in  1  synchronous, active-high reset.
i_enable  in  1  pipeline advance; 0 = stall (hold state, no memory write).
i_alu_result  in  BUS_WIDTH  effective byte address / ALU result from EX/MEM.
i_store_data  in  BUS_WIDTH  rt value for stores.
i_mem_read  in  1  load instruction.
i_mem_write  in  1  store instruction.
i_mem_size  in  2  00 byte, 01 half, 11 word, 10 reserved (treated as word).
i_mem_unsigned  in  1  1 = zero-extend loads (LBU/LHU).
i_mem_to_reg  in  1  WB select, passed through.
i_reg_write  in  1  register-write enable, passed through.
i_rd  in  REG_ADDR_WIDTH  destination register, passed through.
i_debug_addr  in  MEM_ADDR_WIDTH  debug word index.
o_debug_data  out  BUS_WIDTH  mem[i_debug_addr], combinational.
o_alu_result  out  BUS_WIDTH  registered ALU result.
o_mem_result  out  BUS_WIDTH  registered, extended load data.
o_mem_to_reg  out  1  registered.
o_reg_write  out  1  registered.
o_rd  out  REG_ADDR_WIDTH  registered.
o_misaligned  out  1  registered; misaligned access in the instruction now in WB.

Behaviour:
Reset:
- Clears all registered outputs to 0.
- Clears every memory word to 0.
- Takes priority over i_enable.

Addressing:
- Word index = i_alu_result[MEM_ADDR_WIDTH+1:2].
- Higher address bits are ignored, so addresses wrap modulo memory size.
- Byte lane = i_alu_result[1:0], little-endian: lane 0 = bits 7:0.

Misaligned access:
- Half with addr[0]=1, or word with addr[1:0]≠0.
- No memory write occurs.
- Load result is 0.
- o_misaligned=1 for that instruction.

Stores (i_mem_write=1, aligned, i_enable=1):
- Written at the rising edge; only the selected lanes change.
- SB: lane addr[1:0] <= data[7:0].
- SH: lanes {addr[1],0} and {addr[1],1} <= data[15:0].
- SW: all lanes.

Loads:
- Memory read is combinational in the current cycle and captured into o_mem_result at the edge, so data is valid to WB one cycle after the instruction is in MEM.
- Byte/half extraction uses the same lane selection as stores.
- Sign-extend unless i_mem_unsigned=1.
- i_mem_read=0: o_mem_result <= 0.

Simultaneous read and write (illegal encoding):
- The write is performed.
- Captured load data is the pre-write value (read-before-write).

Stall (i_enable=0):
- All MEM/WB outputs hold.
- Memory is not written.
- o_debug_data still tracks i_debug_addr.

Pass-through:
- alu_result, mem_to_reg, reg_write and rd are registered with 1-cycle latency.

Debug port:
- o_debug_data reflects a same-cycle store only after the edge.

Decomposition:
Package mem_pkg holds:
- size encodings MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b11;
- lane/width constants.

Sub-module data_memory:
- byte-enable RAM, synchronous write, synchronous reset clear, two async read ports (pipeline and debug).

Top-level mem_stage contains:
- byte-enable generation;
- misalignment check;
- load extraction/extension;
- the MEM/WB register.

Test Plan:
1. Reset: assert i_reset 2 cycles after random traffic -> all outputs 0; debug dump of all words returns 0.
2. SW 0xDEADBEEF to addr 0x8, then LW addr 0x8 -> o_mem_result=0xDEADBEEF one cycle after load; LB addr 0x9 -> 0xFFFFFFBE; LBU addr 0x9 -> 0x000000BE; LH addr 0xA -> 0xFFFFDEAD.
3. SB 0x11 to addr 0xB over word 0xDEADBEEF -> debug word 2 = 0x11ADBEEF; SH 0x2222 to addr 0x8 -> 0x11AD2222.
4. Misaligned: SW to addr 0x6 -> memory unchanged, o_misaligned=1; LH addr 0x3 -> o_mem_result=0, o_misaligned=1.
5. Stall: hold i_enable=0 for 3 cycles with SW pending -> outputs frozen, no write; raise enable -> write occurs, outputs advance.
6. Wrap: SW 0xA5A5A5A5 to addr 0x80 (MEM_ADDR_WIDTH=5) -> word 0 written; pass-through rd=17, reg_write=1, mem_to_reg=1 appear on outputs one cycle later.
